// File: rtl/fft_frame_sched.sv
// fft_frame_sched
// Shares one FFT/IFFT core between two requesters. A round-robin arbiter picks
// a frame, streams its N = 2^TOTAL_STAGE_P samples from the winner's buffer
// into the core, and tracks in-flight frames so that each requester gets a
// done pulse when the core emits the last output sample of its frame.
// Optional feature macro: FFT_SCHED_TIMEOUT_EN (watchdog + sticky err).
module fft_frame_sched #(
    parameter int TOTAL_STAGE_P = 10,
    parameter int MULT_WIDTH_P  = 18,
    parameter int MAX_INFLIGHT  = 2
) (
    input  logic                     iclk,
    input  logic                     rst_n,
    input  logic [1:0]               req,
    input  logic [1:0]               req_inv,
    output logic [1:0]               gnt,
    output logic                     rd_sel,
    output logic                     rd_en,
    output logic [TOTAL_STAGE_P-1:0] rd_addr,
    input  logic [MULT_WIDTH_P-1:0]  rd_real,
    input  logic [MULT_WIDTH_P-1:0]  rd_imag,
    output logic                     core_en,
    output logic [TOTAL_STAGE_P-1:0] core_addr,
    output logic [MULT_WIDTH_P-1:0]  core_real,
    output logic [MULT_WIDTH_P-1:0]  core_imag,
    output logic                     core_inv,
    input  logic                     core_oen,
    input  logic [TOTAL_STAGE_P-1:0] core_oaddr,
    output logic [1:0]               done,
    output logic [2:0]               inflight,
    output logic                     err
);

    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int SLOTS = 2 ** PTR_W;
    localparam logic [TOTAL_STAGE_P-1:0] LAST_ADDR = {TOTAL_STAGE_P{1'b1}};
    localparam logic [TOTAL_STAGE_P-1:0] ADDR_ZERO = {TOTAL_STAGE_P{1'b0}};
    localparam logic [TOTAL_STAGE_P-1:0] ADDR_ONE  = TOTAL_STAGE_P'(1);
    localparam logic [2:0]               MAX_CNT   = 3'(MAX_INFLIGHT);
    localparam logic [PTR_W-1:0]         PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]         PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]         PTR_LAST  = PTR_W'(MAX_INFLIGHT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Circular increment of an owner-FIFO pointer over MAX_INFLIGHT slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    state_t                     state_q, state_d;
    logic [1:0]                 gnt_q, gnt_d;
    logic                       rd_sel_q, rd_sel_d;
    logic                       rd_en_q, rd_en_d;
    logic [TOTAL_STAGE_P-1:0]   rd_addr_q, rd_addr_d;
    logic                       core_inv_q, core_inv_d;
    logic                       last_q, last_d;
    logic                       core_en_q;
    logic [TOTAL_STAGE_P-1:0]   core_addr_q;
    logic [1:0]                 done_q, done_d;
    logic [2:0]                 inflight_q, inflight_d;
    logic [SLOTS-1:0]           owner_q, owner_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;

    logic                       cand_s;
    logic                       grant_s;
    logic                       cpl_s;
    logic                       pop_s;
    logic                       flush_s;

    // Candidate choice: a lone requester wins, otherwise the one not granted last.
    always_comb begin
        cand_s = 1'b0;
        case (req)
            2'b01:   cand_s = 1'b0;
            2'b10:   cand_s = 1'b1;
            2'b11:   cand_s = ~last_q;
            default: cand_s = 1'b0;
        endcase
    end

    // A blocked candidate (capacity or mode) stalls arbitration rather than
    // letting the other requester overtake it, so a mode switch cannot starve.
    assign grant_s = (state_q == ST_IDLE) && req[cand_s] && (inflight_q < MAX_CNT) &&
                     ((inflight_q == 3'd0) || (req_inv[cand_s] == core_inv_q));

    assign cpl_s = core_oen && (core_oaddr == LAST_ADDR);
    assign pop_s = cpl_s && (inflight_q != 3'd0);

    // Stream FSM next-state: grant launches a frame, STREAM walks 0..N-1.
    always_comb begin
        state_d    = state_q;
        gnt_d      = 2'b00;
        rd_sel_d   = rd_sel_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = ADDR_ZERO;
        core_inv_d = core_inv_q;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d    = ST_STREAM;
                    gnt_d      = cand_s ? 2'b10 : 2'b01;
                    rd_sel_d   = cand_s;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = ADDR_ZERO;
                    core_inv_d = req_inv[cand_s];
                    last_d     = cand_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_STREAM;
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stream FSM state and registered read-side outputs.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 2'b00;
            rd_sel_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= ADDR_ZERO;
            core_inv_q <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rd_sel_q   <= rd_sel_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            core_inv_q <= core_inv_d;
            last_q     <= last_d;
        end
    end

    // Core input strobe/address trail the buffer read by its 1-cycle latency.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            core_en_q   <= 1'b0;
            core_addr_q <= ADDR_ZERO;
        end else begin
            core_en_q   <= rd_en_q;
            core_addr_q <= rd_addr_q;
        end
    end

    // Owner FIFO and in-flight count. Every queued frame shares the current
    // core_inv (mode only changes when the FIFO is empty), so only the owner
    // needs storing per entry.
    always_comb begin
        owner_d    = owner_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        done_d     = 2'b00;
        if (flush_s) begin
            rd_ptr_d = PTR_ZERO;
            if (grant_s) begin
                owner_d[PTR_ZERO] = cand_s;
                wr_ptr_d          = ptr_inc(PTR_ZERO);
                inflight_d        = 3'd1;
            end else begin
                wr_ptr_d   = PTR_ZERO;
                inflight_d = 3'd0;
            end
        end else begin
            if (grant_s) begin
                owner_d[wr_ptr_q] = cand_s;
                wr_ptr_d          = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                done_d   = owner_q[rd_ptr_q] ? 2'b10 : 2'b01;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({grant_s, pop_s})
                2'b10:   inflight_d = inflight_q + 3'd1;
                2'b01:   inflight_d = inflight_q - 3'd1;
                default: inflight_d = inflight_q;
            endcase
        end
    end

    // Owner FIFO, in-flight counter and done pulse registers.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= {SLOTS{1'b0}};
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            inflight_q <= 3'd0;
            done_q     <= 2'b00;
        end else begin
            owner_q    <= owner_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

`ifdef FFT_SCHED_TIMEOUT_EN
    localparam logic [TOTAL_STAGE_P+3:0] WD_LAST = {(TOTAL_STAGE_P + 4){1'b1}};
    localparam logic [TOTAL_STAGE_P+3:0] WD_ZERO = {(TOTAL_STAGE_P + 4){1'b0}};
    localparam logic [TOTAL_STAGE_P+3:0] WD_ONE  = (TOTAL_STAGE_P + 4)'(1);

    logic [TOTAL_STAGE_P+3:0] wdog_q, wdog_d;
    logic                     err_q, err_d;

    // Watchdog: silent core with frames outstanding for 2^(TOTAL_STAGE_P+4)
    // cycles flushes the FIFO; that or a completion with nothing queued latches err.
    always_comb begin
        wdog_d  = wdog_q;
        err_d   = err_q;
        flush_s = 1'b0;
        if ((inflight_q == 3'd0) || core_oen) begin
            wdog_d = WD_ZERO;
        end else if (wdog_q == WD_LAST) begin
            wdog_d  = WD_ZERO;
            flush_s = 1'b1;
            err_d   = 1'b1;
        end else begin
            wdog_d = wdog_q + WD_ONE;
        end
        if (cpl_s && (inflight_q == 3'd0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= WD_ZERO;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign flush_s = 1'b0;
    assign err     = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign rd_sel    = rd_sel_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign core_en   = core_en_q;
    assign core_addr = core_addr_q;
    assign core_real = rd_real;
    assign core_imag = rd_imag;
    assign core_inv  = core_inv_q;
    assign done      = done_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed self-checking bench for fft_frame_sched (N = 8, MAX_INFLIGHT = 2).
module tb_fft_frame_sched;

    localparam int TS = 3;
    localparam int MW = 8;
    localparam int MI = 2;

`ifdef FFT_SCHED_TIMEOUT_EN
    localparam logic TMO = 1'b1;
`else
    localparam logic TMO = 1'b0;
`endif

    logic          iclk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    req_inv;
    logic [1:0]    gnt;
    logic          rd_sel;
    logic          rd_en;
    logic [TS-1:0] rd_addr;
    logic [MW-1:0] rd_real;
    logic [MW-1:0] rd_imag;
    logic          core_en;
    logic [TS-1:0] core_addr;
    logic [MW-1:0] core_real;
    logic [MW-1:0] core_imag;
    logic          core_inv;
    logic          core_oen;
    logic [TS-1:0] core_oaddr;
    logic [1:0]    done;
    logic [2:0]    inflight;
    logic          err;

    int errors = 0;
    int checks = 0;

    fft_frame_sched #(
        .TOTAL_STAGE_P(TS),
        .MULT_WIDTH_P (MW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .iclk      (iclk),
        .rst_n     (rst_n),
        .req       (req),
        .req_inv   (req_inv),
        .gnt       (gnt),
        .rd_sel    (rd_sel),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_real   (rd_real),
        .rd_imag   (rd_imag),
        .core_en   (core_en),
        .core_addr (core_addr),
        .core_real (core_real),
        .core_imag (core_imag),
        .core_inv  (core_inv),
        .core_oen  (core_oen),
        .core_oaddr(core_oaddr),
        .done      (done),
        .inflight  (inflight),
        .err       (err)
    );

    always #5 iclk = ~iclk;

    // Buffer contents: requester index in the MSB, address in the low bits.
    function automatic logic [MW-1:0] buf_word(input logic sel, input logic [TS-1:0] a);
        return {sel, 4'b1010, a};
    endfunction

    // Two buffers with one-cycle read latency, muxed by rd_sel.
    always @(posedge iclk) begin
        if (rd_en) begin
            rd_real <= buf_word(rd_sel, rd_addr);
            rd_imag <= ~buf_word(rd_sel, rd_addr);
        end else begin
            rd_real <= 8'h00;
            rd_imag <= 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    initial begin
        logic [MW-1:0] w;
        rst_n = 1'b0; req = 2'b00; req_inv = 2'b00; core_oen = 1'b0; core_oaddr = 3'd0;
        step(2);
        check("rst_gnt", gnt, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_sel", rd_sel, 0);
        check("rst_core_en", core_en, 0);
        check("rst_core_addr", core_addr, 0);
        check("rst_core_inv", core_inv, 0);
        check("rst_done", done, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        step(3);

        // Grant timing: req at cycle 5, gnt at 6, 8 reads, then one bubble.
        req = 2'b01;
        step(1);
        check("g_gnt", gnt, 2'b01);
        check("g_rd_addr0", rd_addr, 0);
        check("g_rd_en", rd_en, 1);
        check("g_rd_sel", rd_sel, 0);
        check("g_inflight", inflight, 1);
        check("g_core_en0", core_en, 0);
        for (int k = 1; k < 8; k++) begin
            step(1);
            w = ~buf_word(1'b0, 3'(k - 1));
            check("s_rd_addr", rd_addr, k);
            check("s_rd_en", rd_en, 1);
            check("s_gnt", gnt, 0);
            check("s_core_en", core_en, 1);
            check("s_core_addr", core_addr, k - 1);
            check("s_core_real", core_real, buf_word(1'b0, 3'(k - 1)));
            check("s_core_imag", core_imag, w);
        end
        step(1);
        check("end_rd_en", rd_en, 0);
        check("end_core_en", core_en, 1);
        check("end_core_addr", core_addr, 7);
        check("end_core_real", core_real, buf_word(1'b0, 3'd7));
        check("bubble_gnt", gnt, 0);
        step(1);
        check("next_gnt", gnt, 2'b01);
        check("next_rd_addr", rd_addr, 0);
        check("next_core_en", core_en, 0);
        check("next_inflight", inflight, 2);

        // In-flight limit: no third grant while the core stays silent.
        step(8);
        for (int i = 0; i < 6; i++) begin
            check("lim_gnt", gnt, 0);
            check("lim_inflight", inflight, 2);
            step(1);
        end
        core_oen = 1'b1; core_oaddr = 3'd3;
        step(1);
        core_oen = 1'b0;
        check("nonlast_done", done, 0);
        check("nonlast_inflight", inflight, 2);
        core_oen = 1'b1; core_oaddr = 3'd7;
        step(1);
        core_oen = 1'b0;
        check("cpl_done", done, 2'b01);
        check("cpl_inflight", inflight, 1);
        check("cpl_gnt", gnt, 0);
        step(1);
        check("relim_gnt", gnt, 2'b01);
        check("relim_done", done, 0);
        check("relim_inflight", inflight, 2);
        req = 2'b00;
        core_oen = 1'b1;
        step(1);
        check("drain1_done", done, 2'b01);
        check("drain1_inflight", inflight, 1);
        step(1);
        core_oen = 1'b0;
        check("drain2_done", done, 2'b01);
        check("drain2_inflight", inflight, 0);
        step(7);

        // Round-robin with a completion coinciding with a grant.
        req = 2'b11; req_inv = 2'b00;
        step(1);
        check("rr1_gnt", gnt, 2'b10);
        check("rr1_rd_sel", rd_sel, 1);
        check("rr1_inflight", inflight, 1);
        step(8);
        check("rr1_idle_gnt", gnt, 0);
        core_oen = 1'b1;
        step(1);
        core_oen = 1'b0;
        check("sim_gnt", gnt, 2'b01);
        check("sim_done", done, 2'b10);
        check("sim_inflight", inflight, 1);
        check("sim_rd_sel", rd_sel, 0);
        step(9);
        check("rr3_gnt", gnt, 2'b10);
        check("rr3_inflight", inflight, 2);
        step(9);
        check("rr3_block_gnt", gnt, 0);
        core_oen = 1'b1;
        step(1);
        core_oen = 1'b0;
        check("rr_done_a", done, 2'b01);
        check("rr_done_a_infl", inflight, 1);
        step(1);
        check("rr4_gnt", gnt, 2'b01);
        check("rr4_inflight", inflight, 2);
        req = 2'b00;
        core_oen = 1'b1;
        step(1);
        check("rr_done_b", done, 2'b10);
        step(1);
        core_oen = 1'b0;
        check("rr_done_c", done, 2'b01);
        check("rr_done_c_infl", inflight, 0);
        step(6);

        // Mode drain: IFFT request from requester 1 waits until FIFO empties.
        req = 2'b01; req_inv = 2'b00;
        step(1);
        check("md_gnt0", gnt, 2'b01);
        check("md_inv0", core_inv, 0);
        req = 2'b10; req_inv = 2'b10;
        for (int i = 0; i < 14; i++) begin
            step(1);
            check("md_wait_gnt", gnt, 0);
        end
        core_oen = 1'b1;
        step(1);
        core_oen = 1'b0;
        check("md_done", done, 2'b01);
        check("md_inflight0", inflight, 0);
        check("md_gnt_hold", gnt, 0);
        step(1);
        check("md_gnt1", gnt, 2'b10);
        check("md_inv1", core_inv, 1);
        check("md_inflight1", inflight, 1);
        req = 2'b00;

        // Silent core: watchdog fires after 128 cycles when enabled.
        step(127);
        check("wd_pre_err", err, 0);
        check("wd_pre_infl", inflight, 1);
        step(1);
        check("wd_err", err, TMO);
        check("wd_inflight", inflight, TMO ? 3'd0 : 3'd1);
        check("wd_done", done, 0);

        // Reset mid-frame aborts streaming and clears bookkeeping.
        req = 2'b10; req_inv = 2'b10;
        step(1);
        check("ab_gnt", gnt, 2'b10);
        check("ab_inflight", inflight, TMO ? 3'd1 : 3'd2);
        req = 2'b00;
        step(3);
        check("ab_rd_addr", rd_addr, 3);
        rst_n = 1'b0;
        #1;
        check("ab_rd_en", rd_en, 0);
        check("ab_core_en", core_en, 0);
        check("ab_inflight0", inflight, 0);
        check("ab_core_inv", core_inv, 0);
        check("ab_err", err, 0);
        step(1);
        rst_n = 1'b1;
        core_oen = 1'b1; core_oaddr = 3'd7;
        step(1);
        core_oen = 1'b0;
        check("unexp_done", done, 0);
        check("unexp_inflight", inflight, 0);
        check("unexp_err", err, TMO);
        step(1);
        check("unexp_err_sticky", err, TMO);
        rst_n = 1'b0;
        #1;
        check("final_rst_err", err, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
